// File: rtl/fft_pkg.sv
// Shared FFT package: sample type, butterfly FSM states and {re, im} bus helpers.
// The typed helpers here describe the default component width; blocks with a
// different DW build their own packed struct with the same {re, im} layout.
package fft_pkg;

   localparam int FFT_DW = 25;

   // Complex sample, packed so that the bus is {re, im}
   typedef struct packed {
      logic signed [FFT_DW-1:0] re;
      logic signed [FFT_DW-1:0] im;
   } cplx_t;

   // Butterfly stage states
   typedef enum logic [1:0] {
      ST_FILL  = 2'd0,
      ST_BFLY  = 2'd1,
      ST_PASS  = 2'd2,
      ST_DRAIN = 2'd3
   } state_e;

   function automatic cplx_t cplx_unpack(input logic [2*FFT_DW-1:0] bus);
      cplx_t c;
      c.re = bus[2*FFT_DW-1:FFT_DW];
      c.im = bus[FFT_DW-1:0];
      return c;
   endfunction

   function automatic logic [2*FFT_DW-1:0] cplx_pack(input cplx_t c);
      return {c.re, c.im};
   endfunction

endpackage

// File: rtl/sdf_delay_line.sv
// Circular delay line for the R2SDF butterfly: DEPTH words of W bits, one
// shared read/write pointer. The word under the pointer is visible
// combinationally, so a write in the same cycle replaces it only after it has
// been read (read-before-write).
module sdf_delay_line
   import fft_pkg::*;
#(
   parameter int W     = 50,
   parameter int DEPTH = 16
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         we_i,
   input  logic [W-1:0] wr_data_i,
   output logic [W-1:0] rd_data_o
);

   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] ptr_q;

   assign rd_data_o = mem_q[ptr_q];

   // Storage is never output before being rewritten, so it carries no reset
   always_ff @(posedge clk_i) begin
      if (we_i) mem_q[ptr_q] <= wr_data_i;
   end

   // Pointer advances with every write and wraps naturally (DEPTH is 2^AW)
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)   ptr_q <= '0;
      else if (we_i) ptr_q <= ptr_q + AW'(1);
   end

endmodule

// File: rtl/r2sdf_butterfly.sv
// Radix-2 single-path delay-feedback butterfly stage.
// The first half of each 2*DEPTH block is parked in the delay line; the second
// half is combined with it, the halved sum goes out at once and the halved
// difference is written back and emitted during the next half (or on drain).
// Optional build macro R2SDF_ROUND_EN: round-half-up before the 1/2 scaling
// instead of truncating.
module r2sdf_butterfly
   import fft_pkg::*;
#(
   parameter int DW       = 25,
   parameter int DEPTH    = 16,
   parameter int TW_AW    = 10,
   parameter int TW_SHIFT = 0
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            data_valid_i,
   input  logic [2*DW-1:0] stage_i,
   input  logic            flush_i,
   output logic            ready_o,
   output logic            data_valid_o,
   output logic [2*DW-1:0] butterfly_stage_o,
   output logic [TW_AW-1:0] tw_addr_o
);

   localparam int CW = $clog2(DEPTH);

   typedef struct packed {
      logic signed [DW-1:0] re;
      logic signed [DW-1:0] im;
   } sample_t;

   localparam logic signed [DW+1:0] MAX_V = {3'b000, {(DW-1){1'b1}}};
   localparam logic signed [DW+1:0] MIN_V = {3'b111, {(DW-1){1'b0}}};

   state_e           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             flush_pend_q, flush_pend_d;
   logic             vld_q, vld_d;
   logic [2*DW-1:0]  out_q, out_d;
   logic [TW_AW-1:0] tw_q, tw_d;

   logic             acc;
   logic             adv;
   logic             wrap;
   logic [TW_AW-1:0] idx_addr;
   logic [2*DW-1:0]  dl_rd;
   logic [2*DW-1:0]  dl_wr;
   sample_t          x, d, sum_s, dif_s;

   function automatic logic signed [DW+1:0] sext2(input logic signed [DW-1:0] a);
      return {{2{a[DW-1]}}, a};
   endfunction

   // Only max - min with rounding can exceed DW bits; clamp that single case
   function automatic logic signed [DW-1:0] sat_dw(input logic signed [DW+1:0] v);
      if (v > MAX_V)      return MAX_V[DW-1:0];
      else if (v < MIN_V) return MIN_V[DW-1:0];
      else                return v[DW-1:0];
   endfunction

   // Per-stage 1/2 scaling of a full-precision sum or difference
   function automatic logic signed [DW-1:0] half_scale(input logic signed [DW+1:0] v);
      logic signed [DW+1:0] r;
`ifdef R2SDF_ROUND_EN
      r = (v + $signed({{(DW+1){1'b0}}, 1'b1})) >>> 1;
`else
      r = v >>> 1;
`endif
      return sat_dw(r);
   endfunction

   assign ready_o  = (state_q != ST_DRAIN);
   assign acc      = data_valid_i && ready_o;
   assign adv      = acc || (state_q == ST_DRAIN);
   assign wrap     = adv && (&cnt_q);
   assign idx_addr = TW_AW'(cnt_q) << TW_SHIFT;

   assign x = stage_i;
   assign d = dl_rd;

   assign sum_s.re = half_scale(sext2(d.re) + sext2(x.re));
   assign sum_s.im = half_scale(sext2(d.im) + sext2(x.im));
   assign dif_s.re = half_scale(sext2(d.re) - sext2(x.re));
   assign dif_s.im = half_scale(sext2(d.im) - sext2(x.im));

   sdf_delay_line #(
      .W     (2*DW),
      .DEPTH (DEPTH)
   ) u_dline (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .we_i      (adv),
      .wr_data_i (dl_wr),
      .rd_data_o (dl_rd)
   );

   // Next-state: half-counter, FSM, flush bookkeeping, output word and delay-line write data
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      flush_pend_d = flush_pend_q | flush_i;
      vld_d        = 1'b0;
      out_d        = out_q;
      tw_d         = tw_q;
      dl_wr        = stage_i;

      if (adv) cnt_d = cnt_q + CW'(1);

      case (state_q)
         ST_FILL: begin
            // Nothing stored yet, so a flush here has nothing to drain
            flush_pend_d = 1'b0;
            if (wrap) state_d = ST_BFLY;
         end
         ST_BFLY: begin
            dl_wr = dif_s;
            if (acc) begin
               vld_d = 1'b1;
               out_d = sum_s;
               tw_d  = '0;
            end
            if (wrap) state_d = ST_PASS;
         end
         ST_PASS: begin
            if (acc) begin
               vld_d = 1'b1;
               out_d = dl_rd;
               tw_d  = idx_addr;
            end
            if (wrap) begin
               state_d = ST_BFLY;
            end else if (!acc && (cnt_q == '0) && flush_pend_q) begin
               // A word arriving in the same cycle takes priority over the drain
               state_d      = ST_DRAIN;
               flush_pend_d = 1'b0;
            end
         end
         ST_DRAIN: begin
            dl_wr = dl_rd;
            vld_d = 1'b1;
            out_d = dl_rd;
            tw_d  = idx_addr;
            if (wrap) state_d = ST_FILL;
         end
         default: state_d = ST_FILL;
      endcase
   end

   // State and registered outputs, all cleared by the asynchronous reset
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q      <= ST_FILL;
         cnt_q        <= '0;
         flush_pend_q <= 1'b0;
         vld_q        <= 1'b0;
         out_q        <= '0;
         tw_q         <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         flush_pend_q <= flush_pend_d;
         vld_q        <= vld_d;
         out_q        <= out_d;
         tw_q         <= tw_d;
      end
   end

   assign data_valid_o      = vld_q;
   assign butterfly_stage_o = out_q;
   assign tw_addr_o         = tw_q;

endmodule

// File: tb/tb_r2sdf_butterfly.sv
// Directed bench for r2sdf_butterfly at DEPTH = 2, DW = 25.
// Expectations for odd inputs follow the R2SDF_ROUND_EN build setting.
module tb_r2sdf_butterfly;

   localparam int DW       = 25;
   localparam int DEPTH    = 2;
   localparam int TW_AW    = 10;
   localparam int TW_SHIFT = 0;

   logic              clk      = 1'b0;
   logic              rst_n    = 1'b0;
   logic              dvi      = 1'b0;
   logic              flush    = 1'b0;
   logic [2*DW-1:0]   stage_in = '0;
   logic              ready;
   logic              dvo;
   logic [2*DW-1:0]   bout;
   logic [TW_AW-1:0]  tw;

   r2sdf_butterfly #(
      .DW       (DW),
      .DEPTH    (DEPTH),
      .TW_AW    (TW_AW),
      .TW_SHIFT (TW_SHIFT)
   ) dut (
      .clk_i             (clk),
      .rst_ni            (rst_n),
      .data_valid_i      (dvi),
      .stage_i           (stage_in),
      .flush_i           (flush),
      .ready_o           (ready),
      .data_valid_o      (dvo),
      .butterfly_stage_o (bout),
      .tw_addr_o         (tw)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct { int re; int im; int tw; } rec_t;
   typedef struct { int re; int im; int tw; int cyc; } obs_t;

   obs_t obs[$];
   obs_t mon_o;
   rec_t in_q[$];
   rec_t exp_q[$];

   int n_chk  = 0;
   int n_fail = 0;

   // Output monitor, sampled on the inactive edge
   always @(negedge clk) begin
      if (rst_n && dvo) begin
         mon_o.re  = int'($signed(bout[2*DW-1:DW]));
         mon_o.im  = int'($signed(bout[DW-1:0]));
         mon_o.tw  = int'(tw);
         mon_o.cyc = cyc;
         obs.push_back(mon_o);
      end
   end

   task automatic check(input string name, input int act, input int exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic add_in(input int re, input int im);
      rec_t r;
      r.re = re; r.im = im; r.tw = 0;
      in_q.push_back(r);
   endtask

   task automatic add_exp(input int re, input int im, input int t);
      rec_t r;
      r.re = re; r.im = im; r.tw = t;
      exp_q.push_back(r);
   endtask

   task automatic new_test();
      in_q.delete();
      exp_q.delete();
      obs.delete();
   endtask

   // Called right after a falling edge; returns right after the next one
   task automatic put(input int re, input int im);
      dvi      = 1'b1;
      stage_in = {DW'(re), DW'(im)};
      @(negedge clk);
      dvi      = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse_flush();
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      dvi   = 1'b0;
      flush = 1'b0;
      idle(2);
      rst_n = 1'b1;
      obs.delete();
   endtask

   // Bounded wait covering a whole drain; counts cycles with ready low
   task automatic wait_drain(input string name);
      int low = 0;
      repeat (10) begin
         @(negedge clk);
         if (!ready) low++;
      end
      check(name, low, DEPTH);
   endtask

   task automatic check_obs(input string name);
      check($sformatf("%s count", name), obs.size(), exp_q.size());
      for (int i = 0; i < exp_q.size(); i++) begin
         if (i < obs.size()) begin
            check($sformatf("%s re[%0d]", name, i), obs[i].re, exp_q[i].re);
            check($sformatf("%s im[%0d]", name, i), obs[i].im, exp_q[i].im);
            check($sformatf("%s tw[%0d]", name, i), obs[i].tw, exp_q[i].tw);
         end
      end
   endtask

   task automatic apply_inputs(input int gap);
      for (int i = 0; i < in_q.size(); i++) begin
         put(in_q[i].re, in_q[i].im);
         idle(gap);
      end
   endtask

   initial begin
      int c_first, c2, c3;

      // ---- reset state
      idle(1);
      check("rst data_valid_o", int'(dvo), 0);
      check("rst butterfly_stage_o", int'(bout != '0), 0);
      check("rst tw_addr_o", int'(tw), 0);
      check("rst ready_o", int'(ready), 1);
      rst_n = 1'b1;
      idle(1);

      // ---- test 1: one frame then flush
      new_test();
      add_in(100, 0); add_in(200, 0); add_in(50, 0); add_in(-40, 0);
      add_exp(75, 0, 0); add_exp(80, 0, 0); add_exp(25, 0, 0); add_exp(120, 0, 1);
      apply_inputs(0);
      pulse_flush();
      wait_drain("t1 ready low cycles");
      check_obs("t1");

      // ---- test 3: odd values, straight after the drain (proves return to FILL)
      new_test();
      add_in(3, 0); add_in(-3, 0); add_in(0, 0); add_in(0, 0);
`ifdef R2SDF_ROUND_EN
      add_exp(2, 0, 0); add_exp(-1, 0, 0); add_exp(2, 0, 0); add_exp(-1, 0, 1);
`else
      add_exp(1, 0, 0); add_exp(-2, 0, 0); add_exp(1, 0, 0); add_exp(-2, 0, 1);
`endif
      apply_inputs(0);
      pulse_flush();
      wait_drain("t3 ready low cycles");
      check_obs("t3");

      // ---- test 2: back-to-back frames, no bubbles
      do_reset();
      new_test();
      add_in(100, 0); add_in(200, 0); add_in(50, 0); add_in(-40, 0);
      add_in(10, 0);  add_in(20, 0);  add_in(30, 0); add_in(40, 0);
      add_exp(75, 0, 0); add_exp(80, 0, 0); add_exp(25, 0, 0); add_exp(120, 0, 1);
      add_exp(20, 0, 0); add_exp(30, 0, 0);
      put(100, 0); put(200, 0);
      c_first = cyc;
      for (int i = 2; i < in_q.size(); i++) put(in_q[i].re, in_q[i].im);
      idle(3);
      check_obs("t2");
      for (int i = 0; i < obs.size(); i++)
         check($sformatf("t2 cycle[%0d]", i), obs[i].cyc, c_first + 1 + i);

      // ---- test 4: test 1 vectors with 3 idle cycles between words
      do_reset();
      new_test();
      add_exp(75, 0, 0); add_exp(80, 0, 0); add_exp(25, 0, 0); add_exp(120, 0, 1);
      put(100, 0); idle(3);
      put(200, 0); idle(3);
      c2 = cyc; put(50, 0);  idle(3);
      c3 = cyc; put(-40, 0); idle(3);
      pulse_flush();
      wait_drain("t4 ready low cycles");
      check_obs("t4");
      if (obs.size() >= 2) begin
         check("t4 sum0 cycle", obs[0].cyc, c2 + 1);
         check("t4 sum1 cycle", obs[1].cyc, c3 + 1);
      end

      // ---- test 5: flush during BFLY, input offered during DRAIN is dropped
      do_reset();
      new_test();
      add_exp(75, 0, 0); add_exp(80, 0, 0); add_exp(25, 0, 0); add_exp(120, 0, 1);
      add_exp(2, 0, 0);  add_exp(3, 0, 0);
      put(100, 0); put(200, 0); put(50, 0);
      pulse_flush();
      put(-40, 0);
      begin
         int low = 0;
         for (int i = 0; i < 6; i++) begin
            dvi      = !ready;
            stage_in = {DW'(999), DW'(999)};
            if (!ready) low++;
            @(negedge clk);
         end
         dvi = 1'b0;
         check("t5 ready low cycles", low, DEPTH);
      end
      put(4, 0); put(6, 0); put(0, 0); put(0, 0);
      idle(2);
      check_obs("t5");

      // ---- test 5b: pending flush loses to an input at PASS/cnt=0, drains later
      do_reset();
      new_test();
      add_exp(75, 0, 0); add_exp(80, 0, 0); add_exp(25, 0, 0); add_exp(120, 0, 1);
      add_exp(4, 0, 0);  add_exp(6, 0, 0);  add_exp(3, 0, 0);  add_exp(3, 0, 1);
      put(100, 0); put(200, 0); put(50, 0);
      pulse_flush();
      put(-40, 0); put(7, 0); put(9, 0); put(1, 0); put(3, 0);
      wait_drain("t5b ready low cycles");
      check_obs("t5b");

      // ---- test 6: asynchronous reset mid-BFLY, then a clean complex frame
      do_reset();
      new_test();
      put(100, 0); put(200, 0); put(50, 0);
      check("t6 pre-reset valid", int'(dvo), 1);
      check("t6 pre-reset sum", int'($signed(bout[2*DW-1:DW])), 75);
      #2 rst_n = 1'b0;
      #1;
      check("t6 async valid", int'(dvo), 0);
      check("t6 async data", int'(bout != '0), 0);
      check("t6 async tw", int'(tw), 0);
      idle(2);
      rst_n = 1'b1;
      new_test();
      add_in(10, 4); add_in(20, -6); add_in(30, 1); add_in(40, -9);
`ifdef R2SDF_ROUND_EN
      add_exp(20, 3, 0); add_exp(30, -7, 0); add_exp(-10, 2, 0); add_exp(-10, 2, 1);
`else
      add_exp(20, 2, 0); add_exp(30, -8, 0); add_exp(-10, 1, 0); add_exp(-10, 1, 1);
`endif
      apply_inputs(0);
      pulse_flush();
      wait_drain("t6 ready low cycles");
      check_obs("t6");

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1);
   end

endmodule
